// File: rtl/cnn_pkg.sv
// Shared constants for the CNN datapath: activation/coordinate widths and
// 3x3 window element indices (k = 3*dy + dx, row-major from top-left).
package cnn_pkg;
  localparam int ACT_BITS = 8;
  localparam int W_SIZE   = 12;

  localparam int WIN_TL = 0;
  localparam int WIN_T  = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_L  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_R  = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_B  = 7;
  localparam int WIN_BR = 8;

  function automatic int win_idx(input int dy, input int dx);
    return 3*dy + dx;
  endfunction
endpackage

// File: rtl/cnn_line_ram.sv
// Single-port line buffer, one word per column holding {row r-2, row r-1}.
// Read-before-write: an enabled access returns the old word and shifts the new pixel in.
module cnn_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic                clk,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wpix,
  output logic [2*DATA_W-1:0] rdata
);
  logic [2*DATA_W-1:0] mem [DEPTH];

  // old row r-1 field moves up to the r-2 slot, new pixel becomes row r-1
  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= {mem[addr][DATA_W-1:0], wpix};
    end
  end
endmodule

// File: rtl/cnn_window_gen.sv
// 3x3 zero-padded sliding-window generator (or 1x1 centre-only pass-through).
// Stage 1: line RAM read + input registers; stage 2: column shift, pad mask, output.
module cnn_window_gen #(
  parameter int ACT_BITS  = cnn_pkg::ACT_BITS,
  parameter int W_SIZE    = cnn_pkg::W_SIZE,
  parameter int MAX_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [W_SIZE-1:0]     i_row,
  input  logic [W_SIZE-1:0]     i_col,
  input  logic [ACT_BITS-1:0]   i_pixel,
  input  logic [W_SIZE-1:0]     i_width,
  input  logic [W_SIZE-1:0]     i_height,
  input  logic                  i_is_conv3x3,
  output logic                  o_valid,
  output logic [9*ACT_BITS-1:0] o_win,
  output logic [W_SIZE-1:0]     o_row,
  output logic [W_SIZE-1:0]     o_col,
  output logic                  o_last
);
  import cnn_pkg::*;

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic                  mode3, at_origin, beat_mode3, in_pad, ram_en;
  logic [ACT_BITS-1:0]   beat_pix;
  logic [2*ACT_BITS-1:0] ram_rd;

  // the origin beat carries its own mode so a new frame can follow with no bubble
  assign at_origin  = (i_row == '0) && (i_col == '0);
  assign beat_mode3 = at_origin ? i_is_conv3x3 : mode3;
  assign in_pad     = (i_row == i_height) || (i_col == i_width);
  assign beat_pix   = in_pad ? '0 : i_pixel;
  assign ram_en     = i_valid && !rst && beat_mode3 && (i_col < W_SIZE'(MAX_WIDTH));

  cnn_line_ram #(.DATA_W(ACT_BITS), .DEPTH(MAX_WIDTH), .AW(AW)) u_line_ram (
    .clk   (clk),
    .en    (ram_en),
    .addr  (i_col[AW-1:0]),
    .wpix  (beat_pix),
    .rdata (ram_rd)
  );

  logic                s1_vld, s1_mode, s1_emit, s1_last;
  logic                s1_top, s1_bot, s1_left, s1_right;
  logic [W_SIZE-1:0]   s1_row, s1_col;
  logic [ACT_BITS-1:0] s1_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      mode3  <= 1'b0;
    end else begin
      s1_vld <= i_valid;
      if (i_valid && at_origin) mode3 <= i_is_conv3x3;
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      s1_mode  <= beat_mode3;
      s1_pix   <= beat_mode3 ? beat_pix : i_pixel;
      s1_top   <= i_row == W_SIZE'(1);
      s1_bot   <= i_row == i_height;
      s1_left  <= i_col == W_SIZE'(1);
      s1_right <= i_col == i_width;
      if (beat_mode3) begin
        s1_emit <= (i_row != '0) && (i_col != '0);
        s1_row  <= i_row - W_SIZE'(1);
        s1_col  <= i_col - W_SIZE'(1);
        s1_last <= (i_row == i_height) && (i_col == i_width);
      end else begin
        s1_emit <= 1'b1;
        s1_row  <= i_row;
        s1_col  <= i_col;
        s1_last <= (i_row == i_height - W_SIZE'(1)) && (i_col == i_width - W_SIZE'(1));
      end
    end
  end

  // column index dy: 0 = row r-2, 1 = row r-1, 2 = current row
  logic [2:0][ACT_BITS-1:0] wcol1, wcol2, newcol;
  logic [9*ACT_BITS-1:0]    win;

  assign newcol = {s1_pix, ram_rd[ACT_BITS-1:0], ram_rd[2*ACT_BITS-1:ACT_BITS]};

  always_ff @(posedge clk) begin
    if (s1_vld) begin
      wcol1 <= wcol2;
      wcol2 <= newcol;
    end
  end

  // padding mask is the only thing keeping stale RAM/shift contents off the output
  always_comb begin
    win = '0;
    if (s1_mode) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          if (!((dy == 0 && s1_top) || (dy == 2 && s1_bot) ||
                (dx == 0 && s1_left) || (dx == 2 && s1_right)))
            win[ACT_BITS*win_idx(dy, dx) +: ACT_BITS] =
              (dx == 0) ? wcol1[dy] : (dx == 1) ? wcol2[dy] : newcol[dy];
        end
      end
    end else begin
      win[ACT_BITS*WIN_C +: ACT_BITS] = s1_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_win   <= '0;
      o_row   <= '0;
      o_col   <= '0;
    end else begin
      o_valid <= s1_vld && s1_emit;
      o_last  <= s1_vld && s1_emit && s1_last;
      if (s1_vld && s1_emit) begin
        o_win <= win;
        o_row <= s1_row;
        o_col <= s1_col;
      end
    end
  end
endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: image-level padded-window reference model with an
// expected-arrival queue, plus literal spot values for the documented windows.
module tb_cnn_window_gen;
  localparam int AB = 8;
  localparam int WS = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [WS-1:0] i_row, i_col, i_width, i_height;
  logic [AB-1:0] i_pixel;
  logic          i_is_conv3x3;
  logic          o_valid, o_last;
  logic [71:0]   o_win;
  logic [WS-1:0] o_row, o_col;

  cnn_window_gen #(.ACT_BITS(AB), .W_SIZE(WS), .MAX_WIDTH(128)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_row(i_row), .i_col(i_col),
    .i_pixel(i_pixel), .i_width(i_width), .i_height(i_height),
    .i_is_conv3x3(i_is_conv3x3), .o_valid(o_valid), .o_win(o_win),
    .o_row(o_row), .o_col(o_col), .o_last(o_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          row;
    int          col;
    logic [71:0] win;
    logic        last;
  } ent_t;

  ent_t expq[$];
  ent_t obs[$];
  logic [71:0] t1_win [16];
  int checks = 0;
  int errors = 0;

  logic [7:0] img [0:15][0:127];
  int H = 4, W = 4;
  bit mode_cur = 1'b1;
  int beat11_cyc, first_cyc;

  // window centred at (r,c), taken straight from the image with zero padding
  function automatic logic [71:0] ref_win(input bit m3, input int r, input int c);
    logic [71:0] w;
    int rr, cc;
    w = '0;
    if (!m3) begin
      w[32 +: 8] = img[r][c];
      return w;
    end
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        rr = r + dy - 1;
        cc = c + dx - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[8*(3*dy+dx) +: 8] = img[rr][cc];
      end
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input int c, input bit v);
    ent_t e;
    @(negedge clk);
    i_valid      = v;
    i_row        = r[WS-1:0];
    i_col        = c[WS-1:0];
    i_height     = H[WS-1:0];
    i_width      = W[WS-1:0];
    i_pixel      = (r < H && c < W) ? img[r][c] : 8'($urandom);
    i_is_conv3x3 = (r == 0 && c == 0) ? mode_cur : 1'($urandom_range(0, 1));
    if (v && !rst) begin
      e.cyc = cyc + 2;
      if (mode_cur && r >= 1 && c >= 1) begin
        e.row = r - 1; e.col = c - 1;
        e.win = ref_win(1'b1, r - 1, c - 1);
        e.last = (r - 1 == H - 1) && (c - 1 == W - 1);
        expq.push_back(e);
      end else if (!mode_cur) begin
        e.row = r; e.col = c;
        e.win = ref_win(1'b0, r, c);
        e.last = (r == H - 1) && (c == W - 1);
        expq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic run_frame(input bit m3, input int h, input int w, input int gap_every,
                           input int gap_len, input int stop_r, input int stop_c);
    int nr, nc, n;
    H = h; W = w; mode_cur = m3;
    nr = m3 ? h + 1 : h;
    nc = m3 ? w + 1 : w;
    n = 0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        drive(r, c, 1'b1);
        if (r == 1 && c == 1) beat11_cyc = cyc;
        if (r == 0 && c == 0) first_cyc = cyc;
        n++;
        if (r == stop_r && c == stop_c) return;
        if (gap_every > 0 && n % gap_every == 0) idle(gap_len);
      end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain %0d windows still expected", expq.size());
      expq.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, 72'(o_valid), 72'd0);
    chk({name, "_win"},   o_win,        72'd0);
    chk({name, "_row"},   72'(o_row),   72'd0);
    chk({name, "_col"},   72'(o_col),   72'd0);
    chk({name, "_last"},  72'(o_last),  72'd0);
  endtask

  task automatic fill4x4();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'(16*r + c + 1);
  endtask

  always @(negedge clk) begin
    ent_t o, e;
    if (o_valid) begin
      o.cyc = cyc; o.row = int'(o_row); o.col = int'(o_col); o.win = o_win; o.last = o_last;
      obs.push_back(o);
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL window_unexpected at (%0d,%0d) cyc %0d", o_row, o_col, cyc);
      end else begin
        e = expq.pop_front();
        if (e.cyc != cyc || e.row != o.row || e.col != o.col || e.win !== o_win || e.last !== o_last) begin
          errors++;
          $display("FAIL window got cyc %0d (%0d,%0d) %h last %0b want cyc %0d (%0d,%0d) %h last %0b",
                   cyc, o.row, o.col, o_win, o_last, e.cyc, e.row, e.col, e.win, e.last);
        end
      end
    end else begin
      if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        checks++; errors++;
        e = expq.pop_front();
        $display("FAIL window_missing got none want (%0d,%0d) at cyc %0d", e.row, e.col, e.cyc);
      end
      if (o_last) begin
        checks++; errors++;
        $display("FAIL last_without_valid got 1 want 0");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] lit_first, lit_last, w;
    lit_first = {8'd18, 8'd17, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    lit_last  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd52, 8'd51, 8'd0, 8'd36, 8'd35};
    fill4x4();
    rst = 1'b1; i_valid = 1'b0; i_row = '0; i_col = '0; i_pixel = '0;
    i_width = 12'd4; i_height = 12'd4; i_is_conv3x3 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero_outputs("reset");

    // 3x3 contiguous
    obs.delete();
    run_frame(1'b1, 4, 4, 0, 0, -1, -1);
    idle(2); drain();
    chk("t1_count", 72'(obs.size()), 72'd16);
    if (obs.size() == 16) begin
      chk("t1_first_win", obs[0].win, lit_first);
      chk("t1_first_lat", 72'(obs[0].cyc - beat11_cyc), 72'd2);
      chk("t1_first_rc", {32'(obs[0].row), 32'(obs[0].col)}, 72'd0);
      chk("t1_last_win", obs[15].win, lit_last);
      chk("t1_last_flag", 72'(obs[15].last), 72'd1);
      chk("t1_last_rc", {32'(obs[15].row), 32'(obs[15].col)}, {32'd3, 32'd3});
      for (int i = 0; i < 16; i++) t1_win[i] = obs[i].win;
    end

    // same image with 3-cycle gaps every 2 beats
    obs.delete();
    run_frame(1'b1, 4, 4, 2, 3, -1, -1);
    idle(2); drain();
    chk("gap_count", 72'(obs.size()), 72'd16);
    if (obs.size() == 16)
      for (int i = 0; i < 16; i++) chk($sformatf("gap_win%0d", i), obs[i].win, t1_win[i]);

    // 1x1 mode
    obs.delete();
    run_frame(1'b0, 4, 4, 0, 0, -1, -1);
    idle(2); drain();
    chk("p1_count", 72'(obs.size()), 72'd16);
    if (obs.size() == 16) begin
      chk("p1_lat", 72'(obs[0].cyc - first_cyc), 72'd2);
      chk("p1_win5", obs[5].win, 72'd18 << 32);
      chk("p1_last", 72'(obs[15].last), 72'd1);
      chk("p1_last_rc", {32'(obs[15].row), 32'(obs[15].col)}, {32'd3, 32'd3});
    end

    // reset after beat (2,1), with a beat offered during reset, then a fresh frame
    run_frame(1'b1, 4, 4, 0, 0, 2, 1);
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_row = '0; i_col = '0; i_pixel = 8'd99; i_is_conv3x3 = 1'b0;
    while (expq.size() > 0 && expq[expq.size()-1].cyc > cyc) void'(expq.pop_back());
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero_outputs("rst_mid");
    @(negedge clk);
    chk("rst_after_valid", 72'(o_valid), 72'd0);
    obs.delete();
    run_frame(1'b1, 4, 4, 0, 0, -1, -1);
    idle(2); drain();
    chk("rf_count", 72'(obs.size()), 72'd16);
    if (obs.size() == 16)
      for (int i = 0; i < 16; i++) chk($sformatf("rf_win%0d", i), obs[i].win, t1_win[i]);

    // full-width random image
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 128; c++) img[r][c] = 8'($urandom);
    obs.delete();
    run_frame(1'b1, 2, 128, 0, 0, -1, -1);
    idle(2); drain();
    chk("wide_count", 72'(obs.size()), 72'd256);
    if (obs.size() == 256) begin
      w = obs[255].win;
      chk("wide_rc", {32'(obs[255].row), 32'(obs[255].col)}, {32'd1, 32'd127});
      chk("wide_pad_zero", 72'({w[71:48], w[47:40], w[23:16]}), 72'd0);
      chk("wide_centre", 72'(w[39:32]), 72'(img[1][127]));
      chk("wide_tl", 72'(w[7:0]), 72'(img[0][126]));
    end

    // 3x3 then 1x1 back-to-back
    fill4x4();
    obs.delete();
    run_frame(1'b1, 4, 4, 0, 0, -1, -1);
    run_frame(1'b0, 4, 4, 0, 0, -1, -1);
    idle(2); drain();
    chk("ms_count", 72'(obs.size()), 72'd32);
    if (obs.size() == 32) begin
      chk("ms_last3", 72'(obs[15].last), 72'd1);
      chk("ms_last3_win", obs[15].win, lit_last);
      for (int i = 16; i < 32; i++)
        chk($sformatf("ms_centre_only%0d", i - 16), obs[i].win & ~(72'hFF << 32), 72'd0);
      chk("ms_last1", 72'(obs[31].last), 72'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_window_gen.md
# cnn_window_gen

3x3 sliding-window generator that sits between the raster-scan control FSM (`cnn_fsm`) and the convolution MAC array. It consumes one 8-bit activation per cycle, tagged with row and column, and buffers the two previous rows in an on-chip line RAM. It emits a zero-padded 3x3 window centred on each output pixel, or a centre-only window in 1x1 mode.

## Interface
Parameters:
- `ACT_BITS`, 8, activation width.
- `W_SIZE`, 12, row/column/dimension width.
- `MAX_WIDTH`, 128, line RAM depth, which is the maximum image width.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `i_valid`  in  1  — pixel strobe; driven by `ctrl_data_run`.
- `i_row`, `i_col`  in  `W_SIZE`  — scan coordinates of `i_pixel`.
- `i_pixel`  in  `ACT_BITS`  — input activation.
- `i_width`, `i_height`  in  `W_SIZE`  — image dimensions W and H.
- `i_is_conv3x3`  in  1  — 1: 3x3 window; 0: 1x1 pass-through.
- `o_valid`  out  1  — window strobe.
- `o_win`  out  `9*ACT_BITS`  — window; element k=3*dy+dx sits at `[ACT_BITS*k +: ACT_BITS]`. k=0 is top-left, k=4 is the centre.
- `o_row`, `o_col`  out  `W_SIZE`  — centre coordinates of the window.
- `o_last`  out  1  — asserted with the window centred at (H-1, W-1).

## Operation
Mode latch:
- `i_is_conv3x3` is registered into `mode3` on a valid beat with `i_row==0 && i_col==0`.
- `mode3` is held for the rest of the frame.

3x3 mode, scan and output rule:
- Upstream scans (H+1) x (W+1) beats.
- On a beat with `i_row==H` or `i_col==W`, `i_pixel` is ignored and treated as 0.
- A beat at input (r,c) produces one window centred at (r-1, c-1), but only if r>=1 and c>=1.
- Beats with r==0 or c==0 produce no output.

3x3 mode, line RAM:
- One word per column, holding {row r-2, row r-1}.
- The RAM is read-before-write.
- A valid beat at column c reads word c and writes {old row r-1 field, pixel}.
- Beats with c >= `MAX_WIDTH` are neither written nor read.

3x3 mode, window register:
- The window is three columns of three rows each.
- Each valid beat shifts col0<-col1 and col1<-col2.
- It then loads col2 <- {RAM row r-2, RAM row r-1, pixel}.

3x3 mode, zero padding is applied at the output register:
- Top row forced to 0 when the centre row is 0.
- Bottom row forced to 0 when the input row is H.
- Left column forced to 0 when the centre column is 0.
- Right column forced to 0 when the input column is W.
- Because of this masking, stale RAM or shift-register contents never reach `o_win`.

1x1 mode:
- Upstream scans H x W beats.
- Every beat outputs k=4 equal to the pixel and all other elements 0.
- `o_row`/`o_col` equal the input coordinates.
- The line RAM is not written.

Stalls and sequencing:
- Gaps in `i_valid` freeze all state; no window is emitted during a gap.
- Windows are emitted strictly in raster order.
- `o_last` is asserted only together with `o_valid`.

Constraint: W <= `MAX_WIDTH`, W >= 1, H >= 1.

## Timing
- Latency from a valid input beat to its `o_valid` is 2 cycles: stage 1 is the RAM read plus registered pixel and coordinates; stage 2 is the shift, mask and output register.
- Throughput: one window per cycle.
- Reset:
  - `o_valid`, `o_last`, `o_win`, `o_row`, `o_col` all return to 0.
  - Pipeline valids and `mode3` (resets to 0) are cleared.
  - Line RAM contents are not cleared; masking makes this safe.
- Reset asserted mid-frame: in-flight beats are dropped and no window is emitted on the cycle after reset.
- Valid beat arriving while `rst`=1: discarded.
- Back-to-back frames: the (0,0) beat of the next frame may directly follow the last beat of the previous frame, with no bubble required.

## Structure
- Shared package `cnn_pkg` holds `ACT_BITS`, `W_SIZE`, and the window index constants (`WIN_TL`=0 … `WIN_C`=4 … `WIN_BR`=8).
- Sub-module `cnn_line_ram`: single-port, read-before-write, synchronous RAM of depth `MAX_WIDTH` and width `2*ACT_BITS`.

## Test plan
Common image for the 3x3 cases: 4x4, pixel p(r,c) = 16r+c+1.
- 3x3 mode, 4x4 image, contiguous scan of 25 beats:
  - The first `o_valid` occurs 2 cycles after input beat (1,1), centre (0,0), window {0,0,0, 0,1,2, 0,17,18}.
  - The window at centre (3,3) is {35,36,0, 51,52,0, 0,0,0} with `o_last`=1.
  - Exactly 16 windows are emitted.
- Same image with `i_valid` deasserted for 3 cycles every 2 beats: the window sequence and values are identical to the contiguous run, and no `o_valid` occurs during gaps.
- 1x1 mode, 4x4 image: 16 windows, each with k=4 equal to p(r,c), others 0, latency 2, and `o_last` at (3,3).
- `rst` pulsed after input beat (2,1), then a fresh 3x3 frame is run:
  - Outputs are 0 the cycle after reset.
  - The new frame's windows match the first test exactly, proving stale RAM contents are masked.
- W=128, H=2 in 3x3 mode with a random image: all 256 windows match a software reference; window (1,127) has the right column and bottom row zero.
- Mode switch between frames (3x3 then 1x1, back-to-back): the first frame ends with a correct `o_last`, and the second frame's windows are centre-only.
